// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide/remainder, valid/ready on both sides. Divider built only with SEQ_ALU_DIV_EN.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_q;
  logic             div_zero_q;

  logic [WIDTH:0]   add_d;
  logic [WIDTH:0]   sub_d;
  logic [WIDTH-1:0] mul_acc_d;
  logic             last_iter_d;

`ifdef SEQ_ALU_DIV_EN
  logic             is_rem_q;
  logic [WIDTH:0]   div_sh_d;
  logic [WIDTH:0]   div_diff_d;
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;
`endif

  // Datapath for the current step: add/sub on raw inputs, one multiply/divide iteration on state
  always_comb begin
    add_d       = {1'b0, a} + {1'b0, b};
    sub_d       = {1'b0, a} - {1'b0, b};
    last_iter_d = (cnt_q == CNT_W'(WIDTH - 1));
    if (opb_q[0]) begin
      mul_acc_d = acc_q + opa_q;
    end else begin
      mul_acc_d = acc_q;
    end
`ifdef SEQ_ALU_DIV_EN
    // Partial remainder in acc_q, dividend shifting out of opa_q while quotient bits shift in
    div_sh_d   = {acc_q, opa_q[WIDTH-1]};
    div_diff_d = div_sh_d - {1'b0, opb_q};
    if (!div_diff_d[WIDTH]) begin
      div_rem_d = div_diff_d[WIDTH-1:0];
      div_quo_d = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_d = div_sh_d[WIDTH-1:0];
      div_quo_d = {opa_q[WIDTH-2:0], 1'b0};
    end
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      opa_q       <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      is_rem_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            carry_q    <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {WIDTH{1'b0}};
            opa_q      <= a;
            opb_q      <= b;
            case (op)
              3'b001: begin
                r_q         <= add_d[WIDTH-1:0];
                carry_q     <= add_d[WIDTH];
                state_q     <= DONE;
                out_valid_q <= 1'b1;
              end
              3'b010: begin
                r_q         <= sub_d[WIDTH-1:0];
                carry_q     <= sub_d[WIDTH];
                state_q     <= DONE;
                out_valid_q <= 1'b1;
              end
              3'b011: begin
                state_q <= MUL;
              end
              3'b100, 3'b101: begin
`ifdef SEQ_ALU_DIV_EN
                if (b == {WIDTH{1'b0}}) begin
                  r_q         <= op[0] ? a : {WIDTH{1'b1}};
                  div_zero_q  <= 1'b1;
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                end else begin
                  is_rem_q <= op[0];
                  state_q  <= DIV;
                end
`else
                r_q         <= {WIDTH{1'b0}};
                state_q     <= DONE;
                out_valid_q <= 1'b1;
`endif
              end
              default: begin
                r_q         <= {WIDTH{1'b0}};
                state_q     <= DONE;
                out_valid_q <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc_q <= mul_acc_d;
          opa_q <= {opa_q[WIDTH-2:0], 1'b0};
          opb_q <= {1'b0, opb_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter_d) begin
            r_q         <= mul_acc_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          acc_q <= div_rem_d;
          opa_q <= div_quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter_d) begin
            r_q         <= is_rem_q ? div_rem_d : div_quo_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign carry     = carry_q;
  assign div_zero  = div_zero_q;

endmodule
